// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared types and constants for the CDB completion stage
package cdb_pkg;

  localparam int         CDB_LANES           = 2;
  localparam logic [4:0] ZERO_REG            = 5'd31;
  localparam int         DEFAULT_QUEUE_DEPTH = 8;

  typedef struct packed {
    logic [4:0]  tag;
    logic [63:0] value;
    logic [63:0] NPC;
    logic [31:0] IR;
  } cdb_entry_t;

  typedef enum logic [1:0] {
    SRC_MEM,
    SRC_EX1,
    SRC_EX2
  } cdb_src_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - result inputs, EX stalls and two-lane CDB outputs
interface cdb_arbiter_if #(
  parameter int PTR_W = 3
);

  logic [31:0]    ex_IR_in_1;
  logic [31:0]    ex_IR_in_2;
  logic [63:0]    ex_NPC_in_1;
  logic [63:0]    ex_NPC_in_2;
  logic [4:0]     ex_dest_reg_in_1;
  logic [4:0]     ex_dest_reg_in_2;
  logic [63:0]    ex_result_in_1;
  logic [63:0]    ex_result_in_2;
  logic           ex_valid_in_1;
  logic           ex_valid_in_2;
  logic [4:0]     MEM_tag_in;
  logic [63:0]    MEM_value_in;
  logic           MEM_valid_in;
  logic           stall_ex_1;
  logic           stall_ex_2;
  logic [4:0]     cdb_tag_1;
  logic [4:0]     cdb_tag_2;
  logic [63:0]    cdb_value_1;
  logic [63:0]    cdb_value_2;
  logic [63:0]    cdb_NPC_1;
  logic [63:0]    cdb_NPC_2;
  logic [31:0]    cdb_IR_1;
  logic [31:0]    cdb_IR_2;
  logic           cdb_valid_1;
  logic           cdb_valid_2;
  logic [PTR_W:0] queue_count;

  modport master (
    output ex_IR_in_1, ex_IR_in_2, ex_NPC_in_1, ex_NPC_in_2,
           ex_dest_reg_in_1, ex_dest_reg_in_2, ex_result_in_1, ex_result_in_2,
           ex_valid_in_1, ex_valid_in_2, MEM_tag_in, MEM_value_in, MEM_valid_in,
    input  stall_ex_1, stall_ex_2, cdb_tag_1, cdb_tag_2, cdb_value_1, cdb_value_2,
           cdb_NPC_1, cdb_NPC_2, cdb_IR_1, cdb_IR_2, cdb_valid_1, cdb_valid_2,
           queue_count
  );

  modport slave (
    input  ex_IR_in_1, ex_IR_in_2, ex_NPC_in_1, ex_NPC_in_2,
           ex_dest_reg_in_1, ex_dest_reg_in_2, ex_result_in_1, ex_result_in_2,
           ex_valid_in_1, ex_valid_in_2, MEM_tag_in, MEM_value_in, MEM_valid_in,
    output stall_ex_1, stall_ex_2, cdb_tag_1, cdb_tag_2, cdb_value_1, cdb_value_2,
           cdb_NPC_1, cdb_NPC_2, cdb_IR_1, cdb_IR_2, cdb_valid_1, cdb_valid_2,
           queue_count
  );

endinterface

// File: rtl/cdb_queue.sv
// rtl/cdb_queue.sv - circular overflow buffer, up to 3 pushes and 2 pops per cycle
module cdb_queue
  import cdb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_QUEUE_DEPTH,
  parameter int PTR_W = 3
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [1:0]     push_num,
  input  cdb_entry_t     push_data [3],
  input  logic [1:0]     pop_num,
  output cdb_entry_t     head_0,
  output cdb_entry_t     head_1,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  cdb_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_num);
      tail  <= tail + PTR_W'(push_num);
      count <= count + (PTR_W+1)'(push_num) - (PTR_W+1)'(pop_num);
    end
  end

  // Storage carries no reset; count alone decides which entries are live.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset && (2'(i) < push_num)) begin
        mem[tail + PTR_W'(i)] <= push_data[i];
      end
    end
  end

  assign head_0 = mem[head];
  assign head_1 = mem[head + PTR_ONE];

  assert property (@(posedge clock) disable iff (reset) count <= (PTR_W+1)'(DEPTH - 2));

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - merges EX1/EX2/MEM results onto a two-lane CDB, oldest first
// Optional build macro: CDB_ZERO_REG_FILTER_EN drops results targeting the zero register.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
  parameter int PTR_W       = 3
) (
  input logic                clock,
  input logic                reset,
  cdb_arbiter_if.slave       bus
);

`ifdef CDB_ZERO_REG_FILTER_EN
  localparam bit FILTER_ZERO = 1'b1;
`else
  localparam bit FILTER_ZERO = 1'b0;
`endif

  cdb_entry_t     src_e   [3];
  logic           src_ok  [3];
  cdb_entry_t     new_e   [4];
  logic [1:0]     n_new;
  cdb_entry_t     push_data [3];
  logic [1:0]     push_num;
  logic [1:0]     pop_num;
  logic [1:0]     skip;
  cdb_entry_t     head_0;
  cdb_entry_t     head_1;
  logic [PTR_W:0] q_count;
  cdb_entry_t     lane_1;
  cdb_entry_t     lane_2;
  logic           lane_v_1;
  logic           lane_v_2;

  cdb_queue #(.DEPTH(QUEUE_DEPTH), .PTR_W(PTR_W)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push_num  (push_num),
    .push_data (push_data),
    .pop_num   (pop_num),
    .head_0    (head_0),
    .head_1    (head_1),
    .count     (q_count)
  );

  assign bus.stall_ex_2  = (q_count >= (PTR_W+1)'(QUEUE_DEPTH - 2));
  assign bus.stall_ex_1  = (q_count >= (PTR_W+1)'(QUEUE_DEPTH - 1));
  assign bus.queue_count = q_count;

  // Accepted inputs in age order (MEM, EX1, EX2), compacted to the front.
  always_comb begin
    src_e[SRC_MEM]  = '{tag: bus.MEM_tag_in, value: bus.MEM_value_in, NPC: '0, IR: '0};
    src_e[SRC_EX1]  = '{tag: bus.ex_dest_reg_in_1, value: bus.ex_result_in_1,
                        NPC: bus.ex_NPC_in_1, IR: bus.ex_IR_in_1};
    src_e[SRC_EX2]  = '{tag: bus.ex_dest_reg_in_2, value: bus.ex_result_in_2,
                        NPC: bus.ex_NPC_in_2, IR: bus.ex_IR_in_2};
    src_ok[SRC_MEM] = bus.MEM_valid_in;
    src_ok[SRC_EX1] = bus.ex_valid_in_1 && !bus.stall_ex_1;
    src_ok[SRC_EX2] = bus.ex_valid_in_2 && !bus.stall_ex_2;
    n_new = '0;
    for (int i = 0; i < 4; i++) new_e[i] = '0;
    for (int s = 0; s < 3; s++) begin
      if (src_ok[s] && !(FILTER_ZERO && (src_e[s].tag == ZERO_REG))) begin
        new_e[n_new] = src_e[s];
        n_new        = n_new + 2'd1;
      end
    end
  end

  // Queued entries always win the lanes; new inputs fill whatever is left.
  always_comb begin
    lane_1   = '0;
    lane_2   = '0;
    lane_v_1 = 1'b0;
    lane_v_2 = 1'b0;
    if (q_count >= (PTR_W+1)'(2)) begin
      pop_num  = 2'd2;
      lane_1   = head_0;
      lane_2   = head_1;
      lane_v_1 = 1'b1;
      lane_v_2 = 1'b1;
    end else if (q_count == (PTR_W+1)'(1)) begin
      pop_num  = 2'd1;
      lane_1   = head_0;
      lane_2   = new_e[0];
      lane_v_1 = 1'b1;
      lane_v_2 = (n_new >= 2'd1);
    end else begin
      pop_num  = 2'd0;
      lane_1   = new_e[0];
      lane_2   = new_e[1];
      lane_v_1 = (n_new >= 2'd1);
      lane_v_2 = (n_new >= 2'd2);
    end
    skip     = 2'(CDB_LANES) - pop_num;
    push_num = (n_new > skip) ? (n_new - skip) : 2'd0;
    for (int i = 0; i < 3; i++) push_data[i] = new_e[skip + 2'(i)];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.cdb_tag_1   <= '0;
      bus.cdb_tag_2   <= '0;
      bus.cdb_value_1 <= '0;
      bus.cdb_value_2 <= '0;
      bus.cdb_NPC_1   <= '0;
      bus.cdb_NPC_2   <= '0;
      bus.cdb_IR_1    <= '0;
      bus.cdb_IR_2    <= '0;
      bus.cdb_valid_1 <= 1'b0;
      bus.cdb_valid_2 <= 1'b0;
    end else begin
      bus.cdb_tag_1   <= lane_1.tag;
      bus.cdb_tag_2   <= lane_2.tag;
      bus.cdb_value_1 <= lane_1.value;
      bus.cdb_value_2 <= lane_2.value;
      bus.cdb_NPC_1   <= lane_1.NPC;
      bus.cdb_NPC_2   <= lane_2.NPC;
      bus.cdb_IR_1    <= lane_1.IR;
      bus.cdb_IR_2    <= lane_2.IR;
      bus.cdb_valid_1 <= lane_v_1;
      bus.cdb_valid_2 <= lane_v_2;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cdb_arbiter_if #(.PTR_W(3)) bus ();

  cdb_arbiter #(.QUEUE_DEPTH(8), .PTR_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [4:0] sb [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [4:0] mt, input logic [63:0] md,
                       input logic v1, input logic [4:0] t1, input logic [63:0] d1,
                       input logic v2, input logic [4:0] t2, input logic [63:0] d2);
    bus.MEM_valid_in     = mv;
    bus.MEM_tag_in       = mt;
    bus.MEM_value_in     = md;
    bus.ex_valid_in_1    = v1;
    bus.ex_dest_reg_in_1 = t1;
    bus.ex_result_in_1   = d1;
    bus.ex_NPC_in_1      = 64'h1000 + 64'(t1);
    bus.ex_IR_in_1       = 32'hE100_0000 | 32'(t1);
    bus.ex_valid_in_2    = v2;
    bus.ex_dest_reg_in_2 = t2;
    bus.ex_result_in_2   = d2;
    bus.ex_NPC_in_2      = 64'h2000 + 64'(t2);
    bus.ex_IR_in_2       = 32'hE200_0000 | 32'(t2);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  // Lanes must carry the two oldest outstanding tags; count is what remains.
  task automatic check_lanes(input string tag);
    if (sb.size() > 0) begin
      check({tag, "_v1"}, 64'(bus.cdb_valid_1), 64'd1);
      check({tag, "_tag1"}, 64'(bus.cdb_tag_1), 64'(sb.pop_front()));
    end else begin
      check({tag, "_v1"}, 64'(bus.cdb_valid_1), 64'd0);
    end
    if (sb.size() > 0) begin
      check({tag, "_v2"}, 64'(bus.cdb_valid_2), 64'd1);
      check({tag, "_tag2"}, 64'(bus.cdb_tag_2), 64'(sb.pop_front()));
    end else begin
      check({tag, "_v2"}, 64'(bus.cdb_valid_2), 64'd0);
    end
    check({tag, "_count"}, 64'(bus.queue_count), 64'(sb.size()));
  endtask

  int drain_cnt [3] = '{3, 1, 0};

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    check("rst_v1", 64'(bus.cdb_valid_1), 64'd0);
    check("rst_v2", 64'(bus.cdb_valid_2), 64'd0);
    check("rst_tag1", 64'(bus.cdb_tag_1), 64'd0);
    check("rst_val1", bus.cdb_value_1, 64'd0);
    check("rst_count", 64'(bus.queue_count), 64'd0);
    check("rst_stall1", 64'(bus.stall_ex_1), 64'd0);
    check("rst_stall2", 64'(bus.stall_ex_2), 64'd0);
    reset = 1'b0;

    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 64'd40, 1'b1, 5'd4, 64'd40);
    tick();
    check("t1_v1", 64'(bus.cdb_valid_1), 64'd1);
    check("t1_tag1", 64'(bus.cdb_tag_1), 64'd3);
    check("t1_val1", bus.cdb_value_1, 64'd40);
    check("t1_npc1", bus.cdb_NPC_1, 64'h1003);
    check("t1_ir1", 64'(bus.cdb_IR_1), 64'hE100_0003);
    check("t1_v2", 64'(bus.cdb_valid_2), 64'd1);
    check("t1_tag2", 64'(bus.cdb_tag_2), 64'd4);
    check("t1_val2", bus.cdb_value_2, 64'd40);
    check("t1_npc2", bus.cdb_NPC_2, 64'h2004);
    check("t1_count", 64'(bus.queue_count), 64'd0);

    drive(1'b1, 5'd7, 64'hAA, 1'b1, 5'd3, 64'd40, 1'b1, 5'd4, 64'd400);
    tick();
    idle();
    check("t2_tag1", 64'(bus.cdb_tag_1), 64'd7);
    check("t2_val1", bus.cdb_value_1, 64'hAA);
    check("t2_npc1", bus.cdb_NPC_1, 64'd0);
    check("t2_ir1", 64'(bus.cdb_IR_1), 64'd0);
    check("t2_tag2", 64'(bus.cdb_tag_2), 64'd3);
    check("t2_ir2", 64'(bus.cdb_IR_2), 64'hE100_0003);
    check("t2_count", 64'(bus.queue_count), 64'd1);
    tick();
    check("t2b_v1", 64'(bus.cdb_valid_1), 64'd1);
    check("t2b_tag1", 64'(bus.cdb_tag_1), 64'd4);
    check("t2b_val1", bus.cdb_value_1, 64'd400);
    check("t2b_npc1", bus.cdb_NPC_1, 64'h2004);
    check("t2b_v2", 64'(bus.cdb_valid_2), 64'd0);
    check("t2b_count", 64'(bus.queue_count), 64'd0);

    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 5'(3*k), 64'(k), 1'b1, 5'(3*k+1), 64'(k), 1'b1, 5'(3*k+2), 64'(k));
      sb.push_back(5'(3*k));
      sb.push_back(5'(3*k+1));
      sb.push_back(5'(3*k+2));
      tick();
      check_lanes("t3");
      check("t3_cnt", 64'(bus.queue_count), 64'(k+1));
      check("t3_stall2", 64'(bus.stall_ex_2), (k == 5) ? 64'd1 : 64'd0);
      check("t3_stall1", 64'(bus.stall_ex_1), 64'd0);
    end

    drive(1'b1, 5'd18, 64'd0, 1'b1, 5'd19, 64'd0, 1'b1, 5'd20, 64'd0);
    sb.push_back(5'd18);
    sb.push_back(5'd19);
    tick();
    check_lanes("t3s");
    check("t3s_cnt", 64'(bus.queue_count), 64'd6);
    check("t3s_stall2", 64'(bus.stall_ex_2), 64'd1);

    drive(1'b1, 5'd21, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    sb.push_back(5'd21);
    tick();
    idle();
    check_lanes("t4a");
    check("t4a_cnt", 64'(bus.queue_count), 64'd5);
    check("t4a_stall2", 64'(bus.stall_ex_2), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_lanes("t4");
      check("t4_cnt", 64'(bus.queue_count), 64'(drain_cnt[i]));
    end

    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'(8+3*k), 64'd1, 1'b1, 5'(9+3*k), 64'd1, 1'b1, 5'(10+3*k), 64'd1);
      sb.push_back(5'(8+3*k));
      sb.push_back(5'(9+3*k));
      sb.push_back(5'(10+3*k));
      tick();
      check_lanes("t5f");
    end
    check("t5_pre_cnt", 64'(bus.queue_count), 64'd4);
    reset = 1'b1;
    drive(1'b1, 5'd20, 64'd0, 1'b1, 5'd21, 64'd0, 1'b1, 5'd22, 64'd0);
    tick();
    check("t5_v1", 64'(bus.cdb_valid_1), 64'd0);
    check("t5_v2", 64'(bus.cdb_valid_2), 64'd0);
    check("t5_cnt", 64'(bus.queue_count), 64'd0);
    check("t5_stall1", 64'(bus.stall_ex_1), 64'd0);
    check("t5_stall2", 64'(bus.stall_ex_2), 64'd0);
    sb.delete();
    reset = 1'b0;
    idle();
    tick();
    check_lanes("t5i");
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd25, 64'h55, 1'b0, 5'd0, 64'd0);
    sb.push_back(5'd25);
    tick();
    idle();
    check_lanes("t5n");
    tick();
    check_lanes("t5e");

    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'd1, 1'b1, 5'd5, 64'd2);
    tick();
    idle();
`ifdef CDB_ZERO_REG_FILTER_EN
    check("t6_v1", 64'(bus.cdb_valid_1), 64'd1);
    check("t6_tag1", 64'(bus.cdb_tag_1), 64'd5);
    check("t6_val1", bus.cdb_value_1, 64'd2);
    check("t6_v2", 64'(bus.cdb_valid_2), 64'd0);
`else
    check("t6_v1", 64'(bus.cdb_valid_1), 64'd1);
    check("t6_tag1", 64'(bus.cdb_tag_1), 64'd31);
    check("t6_v2", 64'(bus.cdb_valid_2), 64'd1);
    check("t6_tag2", 64'(bus.cdb_tag_2), 64'd5);
`endif
    check("t6_cnt", 64'(bus.queue_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
